user_logic_stream_engine: RTL and testbench
===========================================

Name: user_logic_stream_engine

Overview:
- Parametrised successor to the fixed 4-stream user-logic slot. Sits between the PCIe DMA stream/register fabric and user space.
- NUM_CH flattened stream channels, each with a per-channel FIFO.
- Per-channel mode: loopback or pattern generator.
- Memory-mapped control/status registers and per-channel transfer counters.
- Threshold interrupt with a request/acknowledge FSM.

Parameters:
- NUM_CH, 4, number of stream channels (1..8).
- DATA_W, 64, stream word width.
- FIFO_DEPTH, 16, words per channel FIFO (power of 2, >= 2).
- ADDR_W, 20, register address width.

Ports:
- i_user_clk  in  1  sole clock.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_user_data  in  32  register write data.
- i_user_addr  in  ADDR_W  register byte address.
- i_user_wr_req  in  1  single-cycle write strobe.
- i_user_rd_req  in  1  single-cycle read strobe.
- o_user_data  out  32  read data, valid with o_user_rd_ack.
- o_user_rd_ack  out  1  read acknowledge.
- i_pcie_str_data_valid  in  NUM_CH  inbound valid per channel.
- o_pcie_str_ack  out  NUM_CH  inbound accept per channel.
- i_pcie_str_data  in  NUM_CH*DATA_W  inbound data; channel c at [c*DATA_W +: DATA_W].
- o_pcie_str_data_valid  out  NUM_CH  outbound valid.
- i_pcie_str_ack  in  NUM_CH  outbound accept.
- o_pcie_str_data  out  NUM_CH*DATA_W  outbound data.
- o_intr_req  out  1  interrupt request.
- i_intr_ack  in  1  interrupt acknowledge pulse.

Behaviour:
- Reset: one clock, i_user_clk. Reset is synchronous and active-low (i_rst_n).
  - Reset clears all registers, FIFOs, counters and generators.
  - Reset clears all outputs to 0; FSM goes to IDLE.
  - Reset mid-transfer drops FIFO contents with no partial output.
- Handshake: a transfer occurs on any cycle with valid & ack both high. Valid, once high, holds with stable data until accepted.
- Register map (byte address; decode addr[7:2]; addr[ADDR_W-1:8] must be 0, else unmapped):
  - 0x00 CTRL RW.
    - [NUM_CH-1:0]: channel enable.
    - [8+c]: mode (0 loopback, 1 generator).
    - [31]: soft clear, self-clearing.
  - 0x04 STATUS RO.
    - [c]: FIFO empty.
    - [8+c]: FIFO full.
  - 0x08 THRESH RW, 32b.
  - 0x0C INTR_EN RW, [NUM_CH-1:0].
  - 0x10 INTR_STAT, [NUM_CH-1:0], write-1-to-clear.
  - 0x14 SCRATCH RW.
  - 0x40+4c CNT[c] RO: outbound words transferred, 32b, wraps.
  - Unmapped or c>=NUM_CH: reads return 0, writes are ignored.
- Reads: o_user_rd_ack is high exactly 1 cycle after i_user_rd_req, for 1 cycle, with o_user_data. o_user_data is 0 when ack is low. A write and a read in the same cycle are both serviced; the read returns the pre-write value.
- Loopback (enabled, mode 0):
  - o_pcie_str_ack[c] = !full.
  - Show-ahead FIFO; o_pcie_str_data_valid[c] = !empty.
  - Push and pop in the same cycle when not full/empty keep the level unchanged.
  - Full: no push, even if a pop occurs that cycle.
  - Latency in to out is 1 cycle minimum.
- Generator (enabled, mode 1):
  - Inbound ack = 1; data is discarded.
  - Outbound valid = 1; data = per-channel DATA_W counter, starting at 0, +1 per accepted word, wrapping at 2^DATA_W.
  - The FIFO is held, not cleared.
- Disabled channel: ack = 0, valid = 0. FIFO, generator and counter values are retained.
- Mode change while enabled takes effect the next cycle. FIFO contents resume when mode returns to 0.
- Soft clear: one cycle. Flushes all FIFOs and zeros CNT, generators and INTR_STAT. Leaves CTRL[30:0], THRESH and INTR_EN intact.
- Counters: CNT[c] += 1 per outbound transfer.
- Interrupt status: INTR_STAT[c] sets on the cycle CNT[c] becomes equal to THRESH, when THRESH != 0. Set has priority over a simultaneous W1C of the same bit.
- Interrupt FSM (pending = |(INTR_STAT & INTR_EN)):
  - IDLE: pending -> REQ.
  - REQ: o_intr_req = 1; i_intr_ack -> WAIT_CLR (req drops next cycle).
  - WAIT_CLR: !pending -> IDLE. A new status bit while in WAIT_CLR raises no new request until the FSM returns to IDLE.
  - i_intr_ack in IDLE/WAIT_CLR is ignored.

Decomposition:
- Shared package user_logic_pkg:
  - Register offsets (REG_CTRL..REG_CNT_BASE).
  - CTRL bit positions.
  - Interrupt FSM state enum {IDLE, REQ, WAIT_CLR}.
- Sub-module user_logic_sfifo (DATA_W, FIFO_DEPTH): synchronous show-ahead FIFO with flush, full and empty. Instantiated NUM_CH times in a generate loop.

Test Plan:
- Reset, then read 0x00, 0x04, 0x10 -> 0x0, 0x0000000F (NUM_CH=4, all empty), 0x0; all stream outputs 0; ack returned 1 cycle after rd_req.
- CTRL=0x1, push 0xA5A5_0000_0000_0001..0x10 on ch0 with outbound ack low:
  - 16 words are accepted, then ack=0; STATUS[8]=1.
  - Raising the outbound ack drains the words in order; CNT[0] reads 16.
- CTRL=0x202 (ch1 generator), outbound ack always high for 5 cycles -> data 0,1,2,3,4; inbound ch1 ack=1; CNT[1]=5.
- THRESH=3, INTR_EN=0x1, loop 3 words on ch0:
  - INTR_STAT=0x1 and o_intr_req=1.
  - Pulse i_intr_ack -> req drops; write 0x1 to 0x10 -> FSM IDLE, no request.
- Write CTRL=0x80000001 with ch0 FIFO holding 4 words -> FIFO empty, CNT[0]=0; CTRL reads 0x1.
- Assert i_rst_n=0 for 1 cycle mid-burst -> all outputs 0 the following cycle, FIFOs empty, SCRATCH reads 0.

Source files
------------

// File: rtl/user_logic_pkg.sv
// Shared register map, CTRL field positions and interrupt FSM encoding for the
// user-logic stream engine.
package user_logic_pkg;

  localparam logic [7:0] REG_CTRL      = 8'h00;
  localparam logic [7:0] REG_STATUS    = 8'h04;
  localparam logic [7:0] REG_THRESH    = 8'h08;
  localparam logic [7:0] REG_INTR_EN   = 8'h0C;
  localparam logic [7:0] REG_INTR_STAT = 8'h10;
  localparam logic [7:0] REG_SCRATCH   = 8'h14;
  localparam logic [7:0] REG_CNT_BASE  = 8'h40;

  localparam int unsigned CTRL_MODE_LSB = 8;
  localparam int unsigned CTRL_SOFT_CLR = 31;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWaitClr
  } intr_state_e;

  // Writable CTRL bits: enables in [num_ch-1:0], modes in [8 +: num_ch].
  function automatic logic [31:0] ctrl_wr_mask(int unsigned num_ch);
    logic [31:0] m;
    m = '0;
    for (int unsigned i = 0; i < num_ch; i++) begin
      m[i]                 = 1'b1;
      m[CTRL_MODE_LSB + i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/user_logic_sfifo.sv
// Synchronous show-ahead FIFO with flush; push is refused when full, even if a
// pop happens in the same cycle.
module user_logic_sfifo #(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

  logic [PtrW:0]       wr_ptr_q, rd_ptr_q;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
  logic                do_push, do_pop;

  // Extra pointer bit distinguishes full from empty.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                   (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q[PtrW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PtrW-1:0]] <= wdata;
  end

endmodule

// File: rtl/user_logic_stream_engine.sv
// Multi-channel stream engine: per-channel loopback FIFO or pattern generator,
// CSR block, outbound transfer counters and a threshold interrupt.
module user_logic_stream_engine
  import user_logic_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned ADDR_W     = 20
) (
  input  logic                     i_user_clk,
  input  logic                     i_rst_n,
  input  logic [31:0]              i_user_data,
  input  logic [ADDR_W-1:0]        i_user_addr,
  input  logic                     i_user_wr_req,
  input  logic                     i_user_rd_req,
  output logic [31:0]              o_user_data,
  output logic                     o_user_rd_ack,
  input  logic [NUM_CH-1:0]        i_pcie_str_data_valid,
  output logic [NUM_CH-1:0]        o_pcie_str_ack,
  input  logic [NUM_CH*DATA_W-1:0] i_pcie_str_data,
  output logic [NUM_CH-1:0]        o_pcie_str_data_valid,
  input  logic [NUM_CH-1:0]        i_pcie_str_ack,
  output logic [NUM_CH*DATA_W-1:0] o_pcie_str_data,
  output logic                     o_intr_req,
  input  logic                     i_intr_ack
);

  localparam logic [31:0] CtrlMask = ctrl_wr_mask(NUM_CH);

  logic [31:0]       ctrl_q, thresh_q, scratch_q;
  logic [NUM_CH-1:0] intr_en_q, intr_stat_q, intr_stat_d, intr_w1c;
  logic [31:0]       cnt_q [NUM_CH];
  logic [DATA_W-1:0] gen_q [NUM_CH];
  logic [DATA_W-1:0] fifo_rdata [NUM_CH];
  logic [NUM_CH-1:0] fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [NUM_CH-1:0] lb_sel, gm_sel, out_xfer, cnt_hit;
  logic              rd_ack_q;
  logic [31:0]       rd_data_q, rd_val;
  logic              addr_ok, wr_en, soft_clr, pending, intr_req;
  logic [5:0]        reg_idx;
  intr_state_e       state_q, state_d;

  assign addr_ok  = (i_user_addr[ADDR_W-1:8] == '0);
  assign reg_idx  = i_user_addr[7:2];
  assign wr_en    = i_user_wr_req & addr_ok;
  assign soft_clr = wr_en && (reg_idx == REG_CTRL[7:2]) && i_user_data[CTRL_SOFT_CLR];

  assign lb_sel = ctrl_q[NUM_CH-1:0] & ~ctrl_q[CTRL_MODE_LSB +: NUM_CH];
  assign gm_sel = ctrl_q[NUM_CH-1:0] &  ctrl_q[CTRL_MODE_LSB +: NUM_CH];

  // FIFOs only move in loopback mode, so their contents survive a mode swap.
  assign fifo_push = lb_sel & i_pcie_str_data_valid;
  assign fifo_pop  = lb_sel & i_pcie_str_ack;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    user_logic_sfifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (i_user_clk),
      .rst_n (i_rst_n),
      .flush (soft_clr),
      .push  (fifo_push[c]),
      .pop   (fifo_pop[c]),
      .wdata (i_pcie_str_data[c*DATA_W +: DATA_W]),
      .rdata (fifo_rdata[c]),
      .full  (fifo_full[c]),
      .empty (fifo_empty[c])
    );
  end

  always_comb begin
    o_pcie_str_ack        = '0;
    o_pcie_str_data_valid = '0;
    o_pcie_str_data       = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (gm_sel[c]) begin
        o_pcie_str_ack[c]                    = 1'b1;
        o_pcie_str_data_valid[c]             = 1'b1;
        o_pcie_str_data[c*DATA_W +: DATA_W]  = gen_q[c];
      end else if (lb_sel[c]) begin
        o_pcie_str_ack[c]        = ~fifo_full[c];
        o_pcie_str_data_valid[c] = ~fifo_empty[c];
        if (!fifo_empty[c]) o_pcie_str_data[c*DATA_W +: DATA_W] = fifo_rdata[c];
      end
    end
  end

  assign out_xfer = o_pcie_str_data_valid & i_pcie_str_ack;

  always_comb begin
    cnt_hit = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      cnt_hit[c] = out_xfer[c] && (thresh_q != '0) && ((cnt_q[c] + 32'd1) == thresh_q);
    end
  end

  always_ff @(posedge i_user_clk) begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (!i_rst_n || soft_clr) begin
        cnt_q[c] <= '0;
        gen_q[c] <= '0;
      end else begin
        if (out_xfer[c])              cnt_q[c] <= cnt_q[c] + 32'd1;
        if (out_xfer[c] && gm_sel[c]) gen_q[c] <= gen_q[c] + 1'b1;
      end
    end
  end

  always_ff @(posedge i_user_clk) begin
    if (!i_rst_n) begin
      ctrl_q    <= '0;
      thresh_q  <= '0;
      intr_en_q <= '0;
      scratch_q <= '0;
    end else if (wr_en) begin
      case (reg_idx)
        REG_CTRL[7:2]:    ctrl_q    <= i_user_data & CtrlMask;
        REG_THRESH[7:2]:  thresh_q  <= i_user_data;
        REG_INTR_EN[7:2]: intr_en_q <= i_user_data[NUM_CH-1:0];
        REG_SCRATCH[7:2]: scratch_q <= i_user_data;
        default: ;
      endcase
    end
  end

  // A threshold hit wins over a simultaneous write-1-to-clear of the same bit.
  assign intr_w1c    = (wr_en && (reg_idx == REG_INTR_STAT[7:2])) ?
                       i_user_data[NUM_CH-1:0] : '0;
  assign intr_stat_d = (intr_stat_q & ~intr_w1c) | cnt_hit;

  always_ff @(posedge i_user_clk) begin
    if (!i_rst_n || soft_clr) intr_stat_q <= '0;
    else                      intr_stat_q <= intr_stat_d;
  end

  always_comb begin
    rd_val = '0;
    if (addr_ok) begin
      case (reg_idx)
        REG_CTRL[7:2]: rd_val = ctrl_q;
        REG_STATUS[7:2]: begin
          rd_val[NUM_CH-1:0]             = fifo_empty;
          rd_val[CTRL_MODE_LSB +: NUM_CH] = fifo_full;
        end
        REG_THRESH[7:2]:    rd_val = thresh_q;
        REG_INTR_EN[7:2]:   rd_val[NUM_CH-1:0] = intr_en_q;
        REG_INTR_STAT[7:2]: rd_val[NUM_CH-1:0] = intr_stat_q;
        REG_SCRATCH[7:2]:   rd_val = scratch_q;
        default: begin
          for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (reg_idx == 6'(REG_CNT_BASE[7:2] + c)) rd_val = cnt_q[c];
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_user_clk) begin
    if (!i_rst_n) begin
      rd_ack_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rd_ack_q  <= i_user_rd_req;
      rd_data_q <= i_user_rd_req ? rd_val : '0;
    end
  end

  assign o_user_rd_ack = rd_ack_q;
  assign o_user_data   = rd_data_q;

  assign pending = |(intr_stat_q & intr_en_q);

  always_ff @(posedge i_user_clk) begin
    if (!i_rst_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    intr_req = 1'b0;
    unique case (state_q)
      StIdle:    if (pending) state_d = StReq;
      StReq: begin
        intr_req = 1'b1;
        if (i_intr_ack) state_d = StWaitClr;
      end
      StWaitClr: if (!pending) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  assign o_intr_req = intr_req;

endmodule

// File: tb/tb_user_logic_stream_engine.sv
// Directed bench for user_logic_stream_engine with a queue scoreboard for
// loopback data and a reference model for generator data and counters.
module tb_user_logic_stream_engine;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 20;
  localparam logic [63:0] LB_BASE = 64'hA5A5_0000_0000_0000;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [31:0]              user_wdata;
  logic [ADDR_W-1:0]        user_addr;
  logic                     wr_req, rd_req;
  logic [31:0]              user_rdata;
  logic                     rd_ack;
  logic [NUM_CH-1:0]        in_valid, in_ack, out_valid, out_ack;
  logic [NUM_CH*DATA_W-1:0] in_data, out_data;
  logic                     intr_req, intr_ack;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] q0 [$];
  logic [31:0] cnt_model [NUM_CH];
  logic [63:0] gen_model [NUM_CH];
  logic [31:0] tb_ctrl;
  int          n_in0 = 0;
  int          start;

  always #5 clk = ~clk;

  user_logic_stream_engine #(
    .NUM_CH     (NUM_CH),
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (DEPTH),
    .ADDR_W     (ADDR_W)
  ) dut (
    .i_user_clk            (clk),
    .i_rst_n               (rst_n),
    .i_user_data           (user_wdata),
    .i_user_addr           (user_addr),
    .i_user_wr_req         (wr_req),
    .i_user_rd_req         (rd_req),
    .o_user_data           (user_rdata),
    .o_user_rd_ack         (rd_ack),
    .i_pcie_str_data_valid (in_valid),
    .o_pcie_str_ack        (in_ack),
    .i_pcie_str_data       (in_data),
    .o_pcie_str_data_valid (out_valid),
    .i_pcie_str_ack        (out_ack),
    .o_pcie_str_data       (out_data),
    .o_intr_req            (intr_req),
    .i_intr_ack            (intr_ack)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    q0.delete();
    for (int c = 0; c < NUM_CH; c++) begin
      cnt_model[c] = '0;
      gen_model[c] = '0;
    end
  endtask

  // Settle, record this cycle's handshakes in the scoreboard, advance a cycle.
  task automatic step();
    logic [63:0] exp;
    #1;
    if (in_valid[0] && in_ack[0] && tb_ctrl[0] && !tb_ctrl[8]) begin
      q0.push_back(in_data[63:0]);
      n_in0++;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (out_valid[c] && out_ack[c]) begin
        cnt_model[c]++;
        if (tb_ctrl[8+c]) begin
          check("gen_data", out_data[c*DATA_W +: DATA_W], gen_model[c]);
          gen_model[c]++;
        end else if (c == 0 && q0.size() > 0) begin
          exp = q0.pop_front();
          check("lb_data", out_data[63:0], exp);
        end else begin
          check("unexpected_out_valid", 64'(out_valid[c]), 64'd0);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic reg_write(input logic [ADDR_W-1:0] addr, input logic [31:0] d);
    user_addr  = addr;
    user_wdata = d;
    wr_req     = 1'b1;
    step();
    wr_req = 1'b0;
    if (addr == '0) begin
      tb_ctrl = d & 32'h0000_0F0F;
      if (d[31]) clear_model();
    end
  endtask

  task automatic reg_read(input logic [ADDR_W-1:0] addr, input logic [31:0] exp,
                          input string tag);
    user_addr = addr;
    rd_req    = 1'b1;
    step();
    rd_req = 1'b0;
    check(tag, 64'(user_rdata), 64'(exp));
    check({tag, "_ack"}, 64'(rd_ack), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; user_wdata = '0; user_addr = '0; wr_req = 1'b0; rd_req = 1'b0;
    in_valid = '0; in_data = '0; out_ack = '0; intr_ack = 1'b0; tb_ctrl = '0;
    clear_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ack", 64'(in_ack), 64'd0);
    check("rst_out_data", out_data[63:0], 64'd0);
    check("rst_intr_req", 64'(intr_req), 64'd0);
    user_addr = 20'h0;
    rd_req    = 1'b1;
    #1;
    check("rd_ack_same_cycle", 64'(rd_ack), 64'd0);
    step();
    rd_req = 1'b0;
    check("rst_ctrl", 64'(user_rdata), 64'd0);
    check("rst_ctrl_ack", 64'(rd_ack), 64'd1);
    step();
    check("rd_ack_one_cycle", 64'(rd_ack), 64'd0);
    check("rd_data_idle_zero", 64'(user_rdata), 64'd0);
    reg_read(20'h04, 32'h0000_000F, "rst_status");
    reg_read(20'h10, 32'h0, "rst_intr_stat");

    // Loopback fill on ch0 with outbound held off, then drain
    reg_write(20'h00, 32'h1);
    for (int i = 0; i < 20; i++) begin
      in_valid[0]     = 1'b1;
      in_data[63:0]   = LB_BASE + 64'(n_in0 + 1);
      #1;
      check("lb_in_ack", 64'(in_ack[0]), 64'(q0.size() < DEPTH));
      step();
    end
    in_valid[0] = 1'b0;
    check("lb_accepted", 64'(n_in0), 64'(DEPTH));
    step();
    reg_read(20'h04, 32'h0000_010E, "status_full");
    out_ack[0] = 1'b1;
    for (int i = 0; i < 40 && q0.size() != 0; i++) step();
    out_ack[0] = 1'b0;
    check("lb_drained", 64'(q0.size()), 64'd0);
    check("lb_valid_empty", 64'(out_valid[0]), 64'd0);
    reg_read(20'h40, cnt_model[0], "cnt0_after_drain");

    // Generator on ch1
    reg_write(20'h00, 32'h202);
    out_ack[1]  = 1'b1;
    in_valid[1] = 1'b1;
    in_data[127:64] = 64'hDEAD_BEEF_0000_0001;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("gen_in_ack", 64'(in_ack[1]), 64'd1);
      check("ch0_disabled_ack", 64'(in_ack[0]), 64'd0);
      step();
    end
    out_ack[1]  = 1'b0;
    in_valid[1] = 1'b0;
    reg_read(20'h44, 32'd5, "cnt1_gen");

    // Soft clear with ch0 holding 4 words
    reg_write(20'h00, 32'h1);
    for (int i = 0; i < 10 && q0.size() < 4; i++) begin
      in_valid[0]   = 1'b1;
      in_data[63:0] = LB_BASE + 64'(n_in0 + 1);
      step();
    end
    in_valid[0] = 1'b0;
    reg_read(20'h04, 32'h0000_000E, "status_4_words");
    reg_write(20'h00, 32'h8000_0001);
    reg_read(20'h04, 32'h0000_000F, "status_after_clr");
    reg_read(20'h40, 32'h0, "cnt0_after_clr");
    reg_read(20'h44, 32'h0, "cnt1_after_clr");
    reg_read(20'h00, 32'h1, "ctrl_after_clr");

    // Threshold interrupt and request/ack FSM
    reg_write(20'h08, 32'd3);
    reg_write(20'h0C, 32'h1);
    start      = n_in0;
    out_ack[0] = 1'b1;
    for (int i = 0; i < 20 && cnt_model[0] < 3; i++) begin
      in_valid[0]   = (n_in0 - start) < 3;
      in_data[63:0] = LB_BASE + 64'(n_in0 + 1);
      step();
    end
    in_valid[0] = 1'b0;
    out_ack[0]  = 1'b0;
    reg_read(20'h40, 32'd3, "cnt0_thresh");
    reg_read(20'h10, 32'h1, "intr_stat_set");
    check("intr_req_high", 64'(intr_req), 64'd1);
    intr_ack = 1'b1;
    step();
    intr_ack = 1'b0;
    check("intr_req_after_ack", 64'(intr_req), 64'd0);
    reg_write(20'h10, 32'h1);
    repeat (3) step();
    check("intr_req_after_w1c", 64'(intr_req), 64'd0);
    reg_read(20'h10, 32'h0, "intr_stat_cleared");

    // Register boundaries
    reg_write(20'h14, 32'h1234_5678);
    reg_read(20'h14, 32'h1234_5678, "scratch");
    reg_write(20'h114, 32'hFFFF_FFFF);
    reg_read(20'h14, 32'h1234_5678, "scratch_unmapped_wr");
    reg_read(20'h100, 32'h0, "unmapped_rd");
    reg_read(20'h50, 32'h0, "cnt_ch_oob");
    user_addr  = 20'h14;
    user_wdata = 32'hCAFE_F00D;
    wr_req     = 1'b1;
    rd_req     = 1'b1;
    step();
    wr_req = 1'b0;
    rd_req = 1'b0;
    check("rd_wr_same_cycle", 64'(user_rdata), 64'h1234_5678);
    reg_read(20'h14, 32'hCAFE_F00D, "scratch_new");

    // Reset mid-burst
    for (int i = 0; i < 3; i++) begin
      in_valid[0]   = 1'b1;
      in_data[63:0] = LB_BASE + 64'(n_in0 + 1);
      step();
    end
    in_valid[0] = 1'b0;
    rst_n       = 1'b0;
    @(negedge clk);
    rst_n   = 1'b1;
    tb_ctrl = '0;
    clear_model();
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_in_ack", 64'(in_ack), 64'd0);
    check("mid_rst_out_data", out_data[63:0], 64'd0);
    check("mid_rst_rd_ack", 64'(rd_ack), 64'd0);
    check("mid_rst_intr_req", 64'(intr_req), 64'd0);
    reg_read(20'h04, 32'h0000_000F, "mid_rst_status");
    reg_read(20'h14, 32'h0, "mid_rst_scratch");
    reg_read(20'h00, 32'h0, "mid_rst_ctrl");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
